// File: rtl/cassette_recorder.sv
// Oric cassette record path: measures rising-edge periods on the tape output,
// decodes 1/0 bits, frames start/8 data/odd parity/stop and writes bytes to the tape cache.
module cassette_recorder #(
  parameter int AW         = 16,
  parameter int MIN_PERIOD = 2400,
  parameter int SHORT_MAX  = 14976,
  parameter int TIMEOUT    = 48000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          rewind,
  input  logic          tape_in,
  output logic          wr,
  output logic [AW-1:0] addr,
  output logic [7:0]    dout,
  output logic [AW:0]   tape_end,
  output logic          parity_err,
  output logic          full
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, HUNT, DATA, PARITY, STOP} state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          edge_q, edge_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    dout_q, dout_d;
  logic [AW:0]   tape_end_q, tape_end_d;
  logic          perr_q, perr_d;
  logic          full_q, full_d;

  logic rise, timed_out, accept, bit_val;

  always_comb begin
    rise      = sync2_q & ~edge_q;
    timed_out = (cnt_q == CW'(TIMEOUT));
    // The very first edge only starts timing, so no glitch filter applies in IDLE.
    accept    = rise && ((state_q == IDLE) || (cnt_q >= CW'(MIN_PERIOD)));
    bit_val   = (cnt_q <= CW'(SHORT_MAX));

    sync1_d    = tape_in;
    sync2_d    = sync1_q;
    edge_d     = sync2_q;
    state_d    = state_q;
    cnt_d      = timed_out ? cnt_q : cnt_q + CW'(1);
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    wr_d       = 1'b0;
    addr_d     = addr_q;
    dout_d     = dout_q;
    tape_end_d = tape_end_q + {{AW{1'b0}}, wr_q};
    perr_d     = perr_q;
    full_d     = full_q;

    if (!en) begin
      state_d = IDLE;
    end else if (timed_out && (state_q != IDLE)) begin
      state_d = IDLE;
    end else if (accept) begin
      cnt_d = CW'(1);
      unique case (state_q)
        IDLE: state_d = HUNT;
        HUNT: begin
          if (!bit_val) begin
            state_d   = DATA;
            bit_idx_d = 3'd0;
          end
        end
        DATA: begin
          shift_d   = {bit_val, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          state_d = STOP;
          if (!(^{shift_q, bit_val})) perr_d = 1'b1;
          if (!full_q) begin
            wr_d   = 1'b1;
            addr_d = tape_end_q[AW-1:0];
            dout_d = shift_q;
          end
        end
        STOP: state_d = HUNT;
        default: state_d = IDLE;
      endcase
    end

    if (tape_end_d[AW]) full_d = 1'b1;

    // Rewind wins over everything, including a write decided this cycle.
    if (rewind) begin
      state_d    = IDLE;
      wr_d       = 1'b0;
      addr_d     = '0;
      tape_end_d = '0;
      perr_d     = 1'b0;
      full_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      edge_q     <= 1'b0;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      dout_q     <= '0;
      tape_end_q <= '0;
      perr_q     <= 1'b0;
      full_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      edge_q     <= edge_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      tape_end_q <= tape_end_d;
      perr_q     <= perr_d;
      full_q     <= full_d;
    end
  end

  assign wr         = wr_q;
  assign addr       = addr_q;
  assign dout       = dout_q;
  assign tape_end   = tape_end_q;
  assign parity_err = perr_q;
  assign full       = full_q;

endmodule

// File: tb/tb_cassette_recorder.sv
// Bench for cassette_recorder with periods scaled by 1/100 and a 4-byte cache;
// frames are built from rising-edge intervals (100 = bit 1, 200 = bit 0).
module tb_cassette_recorder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b1;
  logic       rewind = 1'b0;
  logic       tape_in = 1'b0;
  logic       wr;
  logic [1:0] addr;
  logic [7:0] dout;
  logic [2:0] tape_end;
  logic       parity_err;
  logic       full;

  cassette_recorder #(.AW(2), .MIN_PERIOD(24), .SHORT_MAX(150), .TIMEOUT(480)) dut (
    .clk(clk), .reset(reset), .en(en), .rewind(rewind), .tape_in(tape_in),
    .wr(wr), .addr(addr), .dout(dout), .tape_end(tape_end),
    .parity_err(parity_err), .full(full)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int last_addr = 0;
  int last_dout = 0;

  always @(negedge clk) begin
    if (wr) begin
      wr_cnt    <= wr_cnt + 1;
      last_addr <= int'(addr);
      last_dout <= int'(dout);
    end
  end

  typedef struct {
    logic [7:0] data;
    logic       par;
    bit         glitch;
    int         nd;
    bit         drop_en;
    bit         rw_par;
    bit         do_rewind;
    int         exp_wr;
    int         exp_addr;
    int         exp_te;
    bit         exp_perr;
    bit         exp_full;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Wait one bit interval, then produce the rising edge that ends it.
  task automatic iv(input int p, input bit g);
    if (g) begin
      repeat (3) tick();
      tape_in = 1'b0;
      repeat (3) tick();
      tape_in = 1'b1;
      repeat (4) tick();
      tape_in = 1'b0;
      repeat (p - 10) tick();
    end else begin
      repeat (p / 2) tick();
      tape_in = 1'b0;
      repeat (p - p / 2) tick();
    end
    tape_in = 1'b1;
  endtask

  task automatic send_frame(input vec_t v);
    tape_in = 1'b1;
    repeat (4) iv(100, 1'b0);
    iv(200, 1'b0);
    for (int i = 0; i < v.nd; i++) begin
      if (v.drop_en && i == 4) en = 1'b0;
      iv(v.data[i] ? 100 : 200, v.glitch && i == 2);
    end
    if (v.nd == 8) begin
      if (v.rw_par) begin
        repeat (v.par ? 50 : 100) tick();
        tape_in = 1'b0;
        repeat (v.par ? 50 : 100) tick();
        tape_in = 1'b1;
        tick();
        tick();
        rewind = 1'b1;
        tick();
        rewind = 1'b0;
      end else begin
        iv(v.par ? 100 : 200, 1'b0);
      end
      iv(100, 1'b0);
    end
  endtask

  task automatic apply_vec(input int idx, input vec_t v);
    int w0;
    if (v.do_rewind) begin
      rewind = 1'b1;
      tick();
      rewind = 1'b0;
      tick();
      chk($sformatf("v%0d rewind tape_end", idx), int'(tape_end), 0);
      chk($sformatf("v%0d rewind full", idx), int'(full), 0);
      chk($sformatf("v%0d rewind parity_err", idx), int'(parity_err), 0);
      chk($sformatf("v%0d rewind addr", idx), int'(addr), 0);
    end
    w0 = wr_cnt;
    send_frame(v);
    repeat (50) tick();
    tape_in = 1'b0;
    repeat (600) tick();
    en = 1'b1;
    tick();
    chk($sformatf("v%0d wr count", idx), wr_cnt - w0, v.exp_wr);
    if (v.exp_wr != 0) begin
      chk($sformatf("v%0d addr", idx), last_addr, v.exp_addr);
      chk($sformatf("v%0d dout", idx), last_dout, int'(v.data));
    end
    chk($sformatf("v%0d tape_end", idx), int'(tape_end), v.exp_te);
    chk($sformatf("v%0d parity_err", idx), int'(parity_err), int'(v.exp_perr));
    chk($sformatf("v%0d full", idx), int'(full), int'(v.exp_full));
  endtask

  initial begin
    vec_t p;
    int   w0;
    //          data   par  gl  nd drop rwp rew  wr addr te perr full
    vecs[0]  = '{8'h16, 1'b0, 0, 8, 0, 0, 0,  1, 0, 1, 0, 0};
    vecs[1]  = '{8'h24, 1'b0, 0, 8, 0, 0, 0,  1, 1, 2, 1, 0};
    vecs[2]  = '{8'hA5, 1'b1, 1, 8, 0, 0, 0,  1, 2, 3, 1, 0};
    vecs[3]  = '{8'h5A, 1'b1, 0, 4, 0, 0, 0,  0, 0, 3, 1, 0};
    vecs[4]  = '{8'h7F, 1'b0, 0, 8, 0, 0, 0,  1, 3, 4, 1, 1};
    vecs[5]  = '{8'h00, 1'b1, 0, 8, 0, 0, 0,  0, 0, 4, 1, 1};
    vecs[6]  = '{8'h16, 1'b0, 0, 8, 0, 0, 1,  1, 0, 1, 0, 0};
    vecs[7]  = '{8'h81, 1'b1, 0, 8, 0, 1, 0,  0, 0, 0, 0, 0};
    vecs[8]  = '{8'h16, 1'b0, 0, 8, 1, 0, 0,  0, 0, 0, 0, 0};
    vecs[9]  = '{8'h24, 1'b1, 0, 8, 0, 0, 0,  1, 0, 1, 0, 0};
    vecs[10] = '{8'h5A, 1'b1, 0, 8, 0, 0, 0,  1, 0, 1, 0, 0};

    repeat (3) tick();
    reset = 1'b0;
    repeat (600) tick();
    chk("reset wr count", wr_cnt, 0);
    chk("reset addr", int'(addr), 0);
    chk("reset dout", int'(dout), 0);
    chk("reset tape_end", int'(tape_end), 0);
    chk("reset parity_err", int'(parity_err), 0);
    chk("reset full", int'(full), 0);

    for (int i = 0; i < 10; i++) apply_vec(i, vecs[i]);

    // Asynchronous reset in the middle of a data field.
    p = vecs[10];
    p.nd = 4;
    send_frame(p);
    repeat (10) tick();
    #2 reset = 1'b1;
    #1;
    chk("async reset tape_end", int'(tape_end), 0);
    chk("async reset dout", int'(dout), 0);
    chk("async reset wr", int'(wr), 0);
    tape_in = 1'b0;
    tick();
    reset = 1'b0;
    w0 = wr_cnt;
    repeat (700) tick();
    chk("post reset wr count", wr_cnt - w0, 0);
    apply_vec(10, vecs[10]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cassette_recorder.md
# cassette_recorder

Tape-record path for the Oric core: decodes the Oric's serial cassette output (K7_TAPEOUT) by measuring rising-edge periods, then frames bits into bytes and writes them into the tape cache. It is the write-side counterpart of the cassette playback block. The cache image it produces (length on `tape_end`) is later returned to the host through `ioctl_upload`. Runs on the 48 MHz system clock.

## Interface
Parameters:
- AW, 16, cache address width; capacity 2^AW bytes
- MIN_PERIOD, 2400, periods shorter than this are glitches (50 us)
- SHORT_MAX, 14976, largest period decoded as bit 1 (312 us); longer decodes as 0
- TIMEOUT, 48000, period counter limit (1 ms) before the block abandons the frame

Ports:
- clk  in  1  48 MHz system clock (clk_48)
- reset  in  1  asynchronous, active-high; one clock, async assert
- en  in  1  recorder armed (cassette relay & record selected)
- rewind  in  1  synchronous; clears address, count and flags
- tape_in  in  1  raw K7_TAPEOUT, asynchronous to clk
- wr  out  1  one-cycle cache write strobe
- addr  out  AW  cache write address
- dout  out  8  byte being written
- tape_end  out  AW+1  bytes written since rewind/reset
- parity_err  out  1  sticky: at least one byte failed parity
- full  out  1  sticky: cache full, later bytes dropped

## Operation
- Input: 2-flop synchronizer, then edge register; a rising edge is detected one cycle after the second flop.
- Period counter: increments every cycle, saturates at TIMEOUT; on an accepted rising edge, period = count, count restarts at 1.
- Edge classification: period < MIN_PERIOD → glitch, ignored completely (count continues); period <= SHORT_MAX → bit 1; otherwise → bit 0.
- States: IDLE, HUNT, DATA, PARITY, STOP.
  - IDLE: first accepted rising edge only starts timing → HUNT. No bit is produced.
  - HUNT: bit 1 ignored (preamble or trailing stop); bit 0 = start bit → DATA, bit index 0.
  - DATA: 8 bits shifted in LSB first → PARITY after the 8th.
  - PARITY: odd parity, so data ones + parity bit must be odd. Then: write byte (wr), set parity_err on mismatch (byte still written) → STOP.
  - STOP: bit 1 → HUNT; bit 0 → framing loss, → HUNT (that 0 is not reused as a start bit).
- Timeout: counter reaches TIMEOUT in any state except IDLE → IDLE; a partial byte is discarded.
- en low: immediately IDLE, partial byte discarded; addr, tape_end and flags are kept.
- Write: wr=1 for exactly one cycle with dout=byte and addr=tape_end[AW-1:0]; tape_end increments the next cycle.
- Full: when tape_end = 2^AW, set full, suppress wr, and drop bytes; decoding continues.
- rewind: tape_end=0, addr=0, parity_err=0, full=0, state IDLE. rewind has priority over a same-cycle write (no wr issued).

## Timing
- Reset values: wr=0, addr=0, dout=0, tape_end=0, parity_err=0, full=0, state IDLE, counters 0.
- Latency: raw tape_in rising edge at cycle N → bit decided at N+3; for the parity edge, wr is high in cycle N+3.
- addr/dout are stable only during the wr cycle; the consumer samples them on wr.
- At most one wr per MIN_PERIOD window; no backpressure, and the cache must accept a write every cycle.
- tape_end width AW+1 lets it represent a full cache (2^AW) without wrapping.

## Test plan
- Reset/idle: assert reset mid-DATA → all outputs 0 asynchronously; no wr after release until a full frame arrives.
- Single byte 0x16: preamble of 4 ones (period 10000), start 0 (20000), data LSB-first, parity 0, stop 1 → one wr, dout=0x16, addr=0, tape_end=1, parity_err=0.
- Parity error: byte 0x24 sent with parity bit 0 (correct is 1) → wr with dout=0x24, parity_err=1 and stays 1 for the following good bytes.
- Glitch and timeout: insert 1000-cycle pulses inside a frame → ignored, byte correct. A 60000-cycle gap after bit 4 → IDLE, no wr; the next full frame is written at the same addr.
- Full/wrap with AW=2: send 5 bytes → 4 writes at addr 0..3, tape_end=4, full=1, 5th byte gives no wr. rewind → tape_end=0, full=0, next byte at addr 0.
- Simultaneous rewind with the parity-completing edge → no wr, tape_end=0; en dropped mid-byte → no wr, tape_end unchanged.
